pd_match_logger: RTL and testbench
==================================

Name: pd_match_logger

Overview:
- Downstream consumer of the multiply/pattern-detect stage.
- Takes the registered product plus its pattern-match flag and keeps running statistics: accumulated sum, match count, consecutive-match run length with a trigger pulse.
- Buffers the matched products in a small first-word-fall-through FIFO, drained by a valid/ready consumer (debug or readout logic).

Parameters:
- DATA_W, 21, product width; equals multiplier output_width+1.
- ACC_W, 32, accumulator width; must be at least DATA_W.
- CNT_W, 16, width of the match, run and drop counters.
- DEPTH, 8, match FIFO depth; power of two, at least 2.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous clear of all statistics and the FIFO.
- in_valid  in  1  product sample qualifier.
- in_data  in  DATA_W  product from the multiplier stage (unsigned).
- in_match  in  1  pattern-detect flag aligned with in_data.
- trig_len  in  CNT_W  run-length trigger threshold; 0 disables the trigger.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts the head entry.
- out_data  out  DATA_W  FIFO head entry.
- acc  out  ACC_W  saturating sum of all valid samples.
- acc_sat  out  1  sticky; acc has saturated.
- match_cnt  out  CNT_W  saturating count of matched samples.
- max_run  out  CNT_W  longest consecutive-match run since clear.
- drop_cnt  out  CNT_W  saturating count of matches lost to a full FIFO.
- trig  out  1  one-cycle pulse when a run reaches trig_len.

Behaviour:
- Reset (rst_n low, asynchronous): all outputs 0, FIFO empty, internal run counter 0.
- clear has priority over in_valid in the same cycle. The sample presented that cycle is discarded. Registered state returns to reset values one cycle later.
- Sample accept (in_valid=1):
  - acc <= min(acc + zero-extended in_data, 2^ACC_W-1).
  - acc_sat is set if the sum overflowed and stays set until clear or reset.
- Match (in_valid & in_match):
  - match_cnt increments and saturates at all-ones.
  - run increments (saturating).
  - max_run <= max(max_run, run+1).
- Non-match valid sample: run <= 0.
- in_valid=0: no statistic changes; run is held.
- trig pulses high for exactly one cycle in the cycle after the accepting edge where run becomes equal to trig_len (trig_len != 0). It does not re-fire while the run continues past trig_len. A new run must start before it can fire again.
- Latency: every statistic is visible one cycle after the accepting edge.
- FIFO:
  - A push occurs on a match when the FIFO is not full, or when it is full but a pop happens in the same cycle.
  - Otherwise the match is dropped: drop_cnt increments (saturating).
  - Pop occurs when out_valid & out_ready.
  - out_data is the head entry, combinational from storage. It is don't-care while out_valid=0 and driven to 0 in simulation.
  - Push into an empty FIFO: out_valid rises the next cycle.
  - Simultaneous push and pop when non-empty: occupancy is unchanged and order is preserved.
  - Pointers are log2(DEPTH)+1 bits with natural wrap. Full/empty come from the MSB compare.
- Handshake: once out_valid is asserted, out_data stays stable until it is popped. Exceptions are clear and reset, which flush the FIFO.

Optional Feature:
- Macro: PD_LOG_TIMESTAMP_EN.
- Defined:
  - A CNT_W-bit free-running cycle counter runs from reset; clear zeroes it.
  - Each FIFO entry stores {timestamp, data}.
  - Extra port out_ts (out, CNT_W) presents the head entry's capture cycle, with the same stability rules as out_data.
- Undefined: no counter, no out_ts port, FIFO width is DATA_W.

Decomposition:
- Package pd_pkg holds:
  - default width constants (PD_DATA_W=21, PD_ACC_W=32, PD_CNT_W=16);
  - a saturating-increment function;
  - a clog2 helper.
- One sub-module, pd_sync_fifo: parameterised width and depth, FWFT, full/empty, push/pop/flush. Reused for both the timestamped and plain entry width.

Test Plan:
- Reset, then 5 valid samples of 100 with in_match=1, out_ready=0 → acc=500, match_cnt=5, max_run=5, out_valid=1, FIFO holds five entries of 100.
- 10 consecutive matches with DEPTH=8 and out_ready=0 → 8 entries stored, drop_cnt=2. Then out_ready=1 → out_data drains in push order over 8 cycles, after which out_valid=0.
- trig_len=3 with match pattern 1,1,1,1,0,1,1,1 → trig pulses exactly twice: the cycle after the 3rd sample and the cycle after the 8th. max_run=4.
- ACC_W=32, acc preloaded near max by repeated 0x1FFFFF samples → acc clamps at 0xFFFFFFFF and acc_sat=1; a later clear returns both to 0.
- FIFO full with out_ready=1 and a matching sample in the same cycle → no drop, occupancy stays 8, the new entry appears last.
- clear asserted together with a matching valid sample, then rst_n pulsed low mid-drain → the sample is ignored and all outputs are 0. Reset takes effect without waiting for a clk edge.

Source files
------------

// File: rtl/pd_pkg.sv
// Shared widths and helpers for the pattern-detect match logger.
package pd_pkg;

  localparam int PD_DATA_W = 21;
  localparam int PD_ACC_W  = 32;
  localparam int PD_CNT_W  = 16;

  function automatic int unsigned pd_clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(n)) r = r + 1;
    return r;
  endfunction

  // Increment v, holding at the all-ones value of a w-bit field (w <= 32).
  function automatic logic [31:0] pd_sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] max_v;
    max_v = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
    return (v >= max_v) ? max_v : v + 32'd1;
  endfunction

endpackage

// File: rtl/pd_sync_fifo.sv
// First-word-fall-through synchronous FIFO with flush; head entry is read
// combinationally from storage and forced to zero while empty.
module pd_sync_fifo
  import pd_pkg::*;
#(
  parameter int WIDTH = PD_DATA_W,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = int'(pd_clog2(DEPTH));

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push_ok, pop_ok;

  // Pointers carry one extra wrap bit: equal slots with differing MSBs means full.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
      if (pop_ok)  rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

  assign rdata = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/pd_match_logger.sv
// Running statistics and matched-product buffer behind the multiply/pattern-detect
// stage. Define PD_LOG_TIMESTAMP_EN to tag each buffered entry with a capture cycle.
module pd_match_logger
  import pd_pkg::*;
#(
  parameter int DATA_W = PD_DATA_W,
  parameter int ACC_W  = PD_ACC_W,
  parameter int CNT_W  = PD_CNT_W,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_match,
  input  logic [CNT_W-1:0]  trig_len,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ACC_W-1:0]  acc,
  output logic              acc_sat,
  output logic [CNT_W-1:0]  match_cnt,
  output logic [CNT_W-1:0]  max_run,
  output logic [CNT_W-1:0]  drop_cnt,
`ifdef PD_LOG_TIMESTAMP_EN
  output logic [CNT_W-1:0]  out_ts,
`endif
  output logic              trig
);

`ifdef PD_LOG_TIMESTAMP_EN
  localparam int ENTRY_W = DATA_W + CNT_W;
`else
  localparam int ENTRY_W = DATA_W;
`endif

  // Readout handshake: an entry leaves the buffer on a clock edge where
  // out_valid & out_ready; out_data holds steady until then (clear/reset excepted).
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             acc_sat_q, acc_sat_d;
  logic [CNT_W-1:0] match_cnt_q, match_cnt_d;
  logic [CNT_W-1:0] run_q, run_d;
  logic [CNT_W-1:0] max_run_q, max_run_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic             trig_q, trig_d;

  logic [ACC_W:0]   acc_sum;
  logic [CNT_W-1:0] run_inc, match_inc, drop_inc;
  logic             fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [ENTRY_W-1:0] fifo_wdata, fifo_rdata;

  assign acc_sum   = {1'b0, acc_q} + {{(ACC_W + 1 - DATA_W){1'b0}}, in_data};
  assign run_inc   = CNT_W'(pd_sat_inc(32'(run_q), CNT_W));
  assign match_inc = CNT_W'(pd_sat_inc(32'(match_cnt_q), CNT_W));
  assign drop_inc  = CNT_W'(pd_sat_inc(32'(drop_cnt_q), CNT_W));

  assign fifo_pop  = ~fifo_empty & out_ready;
  assign fifo_push = in_valid & in_match & ~clear & (~fifo_full | fifo_pop);

  always_comb begin
    acc_d       = acc_q;
    acc_sat_d   = acc_sat_q;
    match_cnt_d = match_cnt_q;
    run_d       = run_q;
    max_run_d   = max_run_q;
    drop_cnt_d  = drop_cnt_q;
    trig_d      = 1'b0;
    if (clear) begin
      acc_d       = '0;
      acc_sat_d   = 1'b0;
      match_cnt_d = '0;
      run_d       = '0;
      max_run_d   = '0;
      drop_cnt_d  = '0;
    end else if (in_valid) begin
      acc_d     = acc_sum[ACC_W] ? '1 : acc_sum[ACC_W-1:0];
      acc_sat_d = acc_sat_q | acc_sum[ACC_W];
      if (in_match) begin
        match_cnt_d = match_inc;
        run_d       = run_inc;
        if (run_inc > max_run_q) max_run_d = run_inc;
        // run_q check stops a run pinned at saturation from re-firing.
        trig_d = (trig_len != '0) && (run_inc == trig_len) && (run_q != trig_len);
        if (!fifo_push) drop_cnt_d = drop_inc;
      end else begin
        run_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      acc_sat_q   <= 1'b0;
      match_cnt_q <= '0;
      run_q       <= '0;
      max_run_q   <= '0;
      drop_cnt_q  <= '0;
      trig_q      <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      acc_sat_q   <= acc_sat_d;
      match_cnt_q <= match_cnt_d;
      run_q       <= run_d;
      max_run_q   <= max_run_d;
      drop_cnt_q  <= drop_cnt_d;
      trig_q      <= trig_d;
    end
  end

`ifdef PD_LOG_TIMESTAMP_EN
  logic [CNT_W-1:0] ts_q, ts_d;

  assign ts_d = clear ? '0 : ts_q + {{(CNT_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ts_q <= '0;
    else        ts_q <= ts_d;
  end

  assign fifo_wdata = {ts_q, in_data};
  assign out_ts     = fifo_rdata[ENTRY_W-1:DATA_W];
`else
  assign fifo_wdata = in_data;
`endif

  pd_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (clear),
    .push  (fifo_push),
    .wdata (fifo_wdata),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign out_valid = ~fifo_empty;
  assign out_data  = fifo_rdata[DATA_W-1:0];
  assign acc       = acc_q;
  assign acc_sat   = acc_sat_q;
  assign match_cnt = match_cnt_q;
  assign max_run   = max_run_q;
  assign drop_cnt  = drop_cnt_q;
  assign trig      = trig_q;

endmodule

// File: tb/tb_pd_match_logger.sv
// Directed self-checking bench for pd_match_logger at default parameters.
module tb_pd_match_logger;

  localparam int DATA_W = 21;
  localparam int ACC_W  = 32;
  localparam int CNT_W  = 16;
  localparam int DEPTH  = 8;

  logic              clk;
  logic              rst_n;
  logic              clear;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_match;
  logic [CNT_W-1:0]  trig_len;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [ACC_W-1:0]  acc;
  logic              acc_sat;
  logic [CNT_W-1:0]  match_cnt;
  logic [CNT_W-1:0]  max_run;
  logic [CNT_W-1:0]  drop_cnt;
  logic              trig;
`ifdef PD_LOG_TIMESTAMP_EN
  logic [CNT_W-1:0]  out_ts;
`endif

  int checks;
  int errors;

  pd_match_logger #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W),
    .CNT_W  (CNT_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_match  (in_match),
    .trig_len  (trig_len),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .acc       (acc),
    .acc_sat   (acc_sat),
    .match_cnt (match_cnt),
    .max_run   (max_run),
    .drop_cnt  (drop_cnt),
`ifdef PD_LOG_TIMESTAMP_EN
    .out_ts    (out_ts),
`endif
    .trig      (trig)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Driver tasks: inputs change 1 time unit after posedge, outputs sampled there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_sample(input logic m, input logic [DATA_W-1:0] d);
    in_valid = 1'b1;
    in_match = m;
    in_data  = d;
    step();
    in_valid = 1'b0;
    in_match = 1'b0;
    in_data  = '0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (acc !== 32'd0 || acc_sat !== 1'b0 || trig !== 1'b0) begin
      errors++;
      $display("FAIL reset_acc: acc=%0h sat=%0b trig=%0b, expected 0/0/0", acc, acc_sat, trig);
    end
    checks++;
    if (match_cnt !== 16'd0 || max_run !== 16'd0 || drop_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_cnt: match=%0d max_run=%0d drop=%0d, expected 0", match_cnt, max_run, drop_cnt);
    end
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0) begin
      errors++;
      $display("FAIL reset_fifo: out_valid=%0b out_data=%0h, expected 0/0", out_valid, out_data);
    end
  endtask

  task automatic test_basic();
    do_clear();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) drive_sample(1'b1, 21'd100);
    checks++;
    if (acc !== 32'd500) begin
      errors++;
      $display("FAIL basic_acc: got %0d expected 500", acc);
    end
    checks++;
    if (match_cnt !== 16'd5 || max_run !== 16'd5) begin
      errors++;
      $display("FAIL basic_cnt: match=%0d max_run=%0d expected 5/5", match_cnt, max_run);
    end
    checks++;
    if (out_valid !== 1'b1 || out_data !== 21'd100) begin
      errors++;
      $display("FAIL basic_head: valid=%0b data=%0d expected 1/100", out_valid, out_data);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== 21'd100) begin
        errors++;
        $display("FAIL basic_drain[%0d]: valid=%0b data=%0d expected 1/100", i, out_valid, out_data);
      end
      step();
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_empty: out_valid=%0b expected 0", out_valid);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_drop_drain();
    do_clear();
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) drive_sample(1'b1, DATA_W'(i + 1));
    checks++;
    if (drop_cnt !== 16'd2 || match_cnt !== 16'd10 || acc !== 32'd55) begin
      errors++;
      $display("FAIL drop_stats: drop=%0d match=%0d acc=%0d expected 2/10/55", drop_cnt, match_cnt, acc);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== DATA_W'(i + 1)) begin
        errors++;
        $display("FAIL drop_drain[%0d]: valid=%0b data=%0d expected 1/%0d", i, out_valid, out_data, i + 1);
      end
      step();
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL drop_empty: out_valid=%0b expected 0", out_valid);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_trigger();
    logic [7:0] pattern;
    int fires;
    pattern = 8'b1110_1111;  // bit i = match flag of sample i
    fires = 0;
    do_clear();
    out_ready = 1'b1;
    trig_len = 16'd3;
    for (int i = 0; i < 8; i++) begin
      drive_sample(pattern[i], 21'd1);
      if (trig === 1'b1) fires++;
      checks++;
      if (trig !== ((i == 2) || (i == 7))) begin
        errors++;
        $display("FAIL trig_sample[%0d]: trig=%0b expected %0b", i, trig, (i == 2) || (i == 7));
      end
    end
    step();
    checks++;
    if (trig !== 1'b0 || fires != 2) begin
      errors++;
      $display("FAIL trig_count: trig=%0b fires=%0d expected 0/2", trig, fires);
    end
    checks++;
    if (max_run !== 16'd4) begin
      errors++;
      $display("FAIL trig_max_run: got %0d expected 4", max_run);
    end
    trig_len = '0;
    out_ready = 1'b0;
  endtask

  task automatic test_saturation();
    do_clear();
    in_valid = 1'b1;
    in_match = 1'b0;
    in_data  = 21'h1FFFFF;
    repeat (2048) step();
    checks++;
    if (acc !== 32'hFFFF_F800 || acc_sat !== 1'b0) begin
      errors++;
      $display("FAIL sat_pre: acc=%0h sat=%0b expected fffff800/0", acc, acc_sat);
    end
    step();
    checks++;
    if (acc !== 32'hFFFF_FFFF || acc_sat !== 1'b1) begin
      errors++;
      $display("FAIL sat_clamp: acc=%0h sat=%0b expected ffffffff/1", acc, acc_sat);
    end
    in_data = 21'd1;
    step();
    in_valid = 1'b0;
    in_data  = '0;
    checks++;
    if (acc !== 32'hFFFF_FFFF || acc_sat !== 1'b1 || match_cnt !== 16'd0) begin
      errors++;
      $display("FAIL sat_hold: acc=%0h sat=%0b match=%0d expected ffffffff/1/0", acc, acc_sat, match_cnt);
    end
    do_clear();
    checks++;
    if (acc !== 32'd0 || acc_sat !== 1'b0) begin
      errors++;
      $display("FAIL sat_clear: acc=%0h sat=%0b expected 0/0", acc, acc_sat);
    end
  endtask

  task automatic test_back_to_back();
    logic [DATA_W-1:0] exp_q[$];
    do_clear();
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive_sample(1'b1, DATA_W'(10 + i));
      exp_q.push_back(DATA_W'(10 + i));
    end
    out_ready = 1'b1;
    drive_sample(1'b1, 21'd99);
    void'(exp_q.pop_front());
    exp_q.push_back(21'd99);
    checks++;
    if (drop_cnt !== 16'd0 || out_data !== 21'd11) begin
      errors++;
      $display("FAIL b2b_nodrop: drop=%0d head=%0d expected 0/11", drop_cnt, out_data);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp_q[i]) begin
        errors++;
        $display("FAIL b2b_drain[%0d]: valid=%0b data=%0d expected 1/%0d", i, out_valid, out_data, exp_q[i]);
      end
      step();
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_empty: out_valid=%0b expected 0", out_valid);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_clear_reset();
    do_clear();
    for (int i = 0; i < 3; i++) drive_sample(1'b1, DATA_W'(5 + i));
    clear = 1'b1;
    drive_sample(1'b1, 21'd77);
    clear = 1'b0;
    checks++;
    if (acc !== 32'd0 || match_cnt !== 16'd0 || max_run !== 16'd0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL clear_prio: acc=%0d match=%0d max_run=%0d valid=%0b expected all 0", acc, match_cnt, max_run, out_valid);
    end
    for (int i = 0; i < 3; i++) drive_sample(1'b1, DATA_W'(5 + i));
    out_ready = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 21'd6) begin
      errors++;
      $display("FAIL mid_drain: valid=%0b data=%0d expected 1/6", out_valid, out_data);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || acc !== 32'd0 || match_cnt !== 16'd0 || max_run !== 16'd0) begin
      errors++;
      $display("FAIL async_reset: valid=%0b data=%0d acc=%0d match=%0d max_run=%0d expected all 0",
               out_valid, out_data, acc, match_cnt, max_run);
    end
    #2;
    rst_n = 1'b1;
    out_ready = 1'b0;
    step();
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    clear     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_match  = 1'b0;
    trig_len  = '0;
    out_ready = 1'b0;
    #12;
    test_reset();
    rst_n = 1'b1;
    step();
    test_basic();
    test_drop_drain();
    test_trigger();
    test_saturation();
    test_back_to_back();
    test_clear_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
